// File: rtl/led_seq_pkg.sv
// Shared constants for the LED pattern sequencer: pattern index encodings
// and the helper that steps through them.
package led_seq_pkg;

  typedef enum logic [1:0] {
    PAT_BIN   = 2'd0,
    PAT_GRAY  = 2'd1,
    PAT_WALK  = 2'd2,
    PAT_BLINK = 2'd3
  } pat_e;

  localparam int NUM_PAT = 4;

  // Four patterns in a 2-bit field: 3 wraps naturally to 0
  function automatic pat_e next_pat(input pat_e p);
    return pat_e'(p + 2'd1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, periodic sampling and a
// one-clock pulse for each debounced rising edge, per bit.
module btn_debounce #(
  parameter int WIDTH   = 2,
  parameter int DEB_CYC = 400000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] press
);

  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic [CW-1:0] cnt;
  logic          sample;
  logic          armed;

  assign sample = (cnt == CW'(DEB_CYC - 1));

  // The first sample after reset only learns the current level, so a button
  // held through reset never yields a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else begin
      cnt <= sample ? '0 : cnt + CW'(1);
      if (sample) armed <= 1'b1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic sync1, sync2, stable, pulse;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1  <= 1'b0;
        sync2  <= 1'b0;
        stable <= 1'b0;
        pulse  <= 1'b0;
      end else begin
        sync1 <= raw[i];
        sync2 <= sync1;
        pulse <= 1'b0;
        if (sample) begin
          stable <= sync2;
          pulse  <= armed & sync2 & ~stable;
        end
      end
    end

    assign press[i] = pulse;
  end

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: prescaled step counter driving one of four
// combinational patterns, with next-pattern and pause/run buttons.
module led_pattern_seq
  import led_seq_pkg::*;
#(
  parameter int NUM_LED   = 3,
  parameter int NUM_STEP  = 8,
  parameter int DIV_WIDTH = 26,
  parameter int DEB_CYC   = 400000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [1:0]         BTN,
  input  logic [1:0]         SPEED,
  output logic [NUM_LED-1:0] LED,
  output logic [1:0]         PAT_IDX,
  output logic               PAUSED
);

  localparam int                   SW      = (NUM_STEP > 1) ? $clog2(NUM_STEP) : 1;
  localparam logic [DIV_WIDTH-1:0] PRE_MAX = '1;
  localparam logic [SW-1:0]        STEP_LAST = SW'(NUM_STEP - 1);

  logic [1:0]           press;
  logic [DIV_WIDTH-1:0] pre;
  logic [DIV_WIDTH-1:0] term;
  logic [SW-1:0]        step;
  pat_e                 pat;
  logic                 paused;
  logic [NUM_LED-1:0]   led_q;
  logic [NUM_LED-1:0]   pat_val;
  logic [NUM_LED-1:0]   s_ext;
  logic [2:0]           walk_pos;

  btn_debounce #(
    .WIDTH   (2),
    .DEB_CYC (DEB_CYC)
  ) u_deb (
    .clk   (CLK),
    .rst_n (RST),
    .raw   (BTN),
    .press (press)
  );

  assign term = PRE_MAX >> SPEED;

  // Tick and pause both act on the registered PAUSED; a pattern change
  // clears the step and prescaler ahead of any tick in the same cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pre    <= '0;
      step   <= '0;
      pat    <= PAT_BIN;
      paused <= 1'b0;
      led_q  <= '0;
    end else begin
      led_q <= pat_val;
      if (press[1]) paused <= ~paused;
      if (press[0]) begin
        pat  <= next_pat(pat);
        pre  <= '0;
        step <= '0;
      end else if (!paused) begin
        if (pre == term) begin
          pre  <= '0;
          step <= (step == STEP_LAST) ? '0 : step + SW'(1);
        end else if (pre > term) begin
          pre <= '0;
        end else begin
          pre <= pre + DIV_WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    s_ext    = NUM_LED'(step);
    walk_pos = 3'(32'(step) % NUM_LED);
    pat_val  = '0;
    case (pat)
      PAT_BIN:   pat_val = s_ext;
      PAT_GRAY:  pat_val = s_ext ^ (s_ext >> 1);
      PAT_WALK:  pat_val = NUM_LED'(1) << walk_pos;
      PAT_BLINK: pat_val = {NUM_LED{step[0]}};
      default:   pat_val = '0;
    endcase
  end

  assign LED     = led_q;
  assign PAT_IDX = pat;
  assign PAUSED  = paused;

endmodule
